// File: rtl/hazard_tracker_pkg.sv
// Shared encodings for the D/E/M/W hazard unit: forward selects, Tuse/Tnew
// constants and the decoded D-stage class summary.
package hazard_tracker_pkg;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_E    = 2'd1,
        FWD_M    = 2'd2,
        FWD_W    = 2'd3
    } fwd_sel_t;

    localparam logic [1:0] TUSE_NONE = 2'd3;
    localparam logic [1:0] TNEW_CALC = 2'd1;
    localparam logic [1:0] TNEW_LOAD = 2'd2;
    localparam logic [1:0] TNEW_JL   = 2'd0;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned TNEW_W = 2;

    typedef struct packed {
        logic [4:0] a3;
        logic [1:0] tnew;
        logic [1:0] tuse_rs;
        logic [1:0] tuse_rt;
    } d_class_t;

    function automatic logic [1:0] sat_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    // A producer can feed operand x only once its value exists (tnew == 0).
    function automatic logic src_hit(input logic [4:0] a3, input logic [4:0] x,
                                     input logic [1:0] tnew);
        return (a3 != REG_ZERO) && (a3 == x) && (tnew == 2'd0);
    endfunction

endpackage

// File: rtl/hazard_tracker_stage_rec.sv
// One pipeline record register: payload plus Tnew, with bubble insertion and
// optional saturating Tnew decrement on load.
module hazard_stage_rec
    import hazard_tracker_pkg::*;
#(
    parameter int unsigned PW  = 15,
    parameter bit          DEC = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              bubble,
    input  logic [PW-1:0]     d_payload,
    input  logic [TNEW_W-1:0] d_tnew,
    output logic [PW-1:0]     q_payload,
    output logic [TNEW_W-1:0] q_tnew
);

    logic [TNEW_W-1:0] tnew_nxt;

    always_comb begin
        tnew_nxt = d_tnew;
        if (DEC) begin
            tnew_nxt = sat_dec(d_tnew);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_payload <= '0;
            q_tnew    <= '0;
        end else if (bubble) begin
            q_payload <= '0;
            q_tnew    <= '0;
        end else begin
            q_payload <= d_payload;
            q_tnew    <= tnew_nxt;
        end
    end

endmodule

// File: rtl/hazard_tracker.sv
// Five-stage MIPS hazard unit: tracks destination/Tnew through E, M, W and
// produces the D-stage stall plus D/E/M forwarding selects.
module hazard_tracker
    import hazard_tracker_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       d_calc_r,
    input  logic       d_calc_i,
    input  logic       d_lui,
    input  logic       d_load,
    input  logic       d_store,
    input  logic       d_branch,
    input  logic       d_jr,
    input  logic       d_j_l,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [4:0] d_rd,
    output logic       stall,
    output logic [1:0] fwd_d_rs,
    output logic [1:0] fwd_d_rt,
    output logic [1:0] fwd_e_rs,
    output logic [1:0] fwd_e_rt,
    output logic [1:0] fwd_m_rt
);

    d_class_t   dc;
    logic [4:0] e_rs, e_rt, e_a3;
    logic [1:0] e_tnew;
    logic [4:0] m_rt, m_a3;
    logic [1:0] m_tnew;
    logic [4:0] w_a3;

    always_comb begin
        dc.a3      = REG_ZERO;
        dc.tnew    = 2'd0;
        dc.tuse_rs = TUSE_NONE;
        dc.tuse_rt = TUSE_NONE;
        if (d_calc_r) begin
            dc.a3 = d_rd;  dc.tnew = TNEW_CALC;
            dc.tuse_rs = 2'd1; dc.tuse_rt = 2'd1;
        end else if (d_calc_i) begin
            dc.a3 = d_rt;  dc.tnew = TNEW_CALC;
            dc.tuse_rs = 2'd1;
        end else if (d_lui) begin
            dc.a3 = d_rt;  dc.tnew = TNEW_CALC;
        end else if (d_load) begin
            dc.a3 = d_rt;  dc.tnew = TNEW_LOAD;
            dc.tuse_rs = 2'd1;
        end else if (d_store) begin
            dc.tuse_rs = 2'd1; dc.tuse_rt = 2'd2;
        end else if (d_branch) begin
            dc.tuse_rs = 2'd0; dc.tuse_rt = 2'd0;
        end else if (d_jr) begin
            dc.tuse_rs = 2'd0;
        end else if (d_j_l) begin
            dc.a3 = REG_RA; dc.tnew = TNEW_JL;
        end
    end

    function automatic logic op_stall(input logic [4:0] x, input logic [1:0] tuse,
                                      input logic [4:0] ea3, input logic [1:0] etn,
                                      input logic [4:0] ma3, input logic [1:0] mtn);
        return (tuse != TUSE_NONE) && (x != REG_ZERO) &&
               (((ea3 == x) && (etn > tuse)) || ((ma3 == x) && (mtn > tuse)));
    endfunction

    always_comb begin
        stall = op_stall(d_rs, dc.tuse_rs, e_a3, e_tnew, m_a3, m_tnew) ||
                op_stall(d_rt, dc.tuse_rt, e_a3, e_tnew, m_a3, m_tnew);
    end

    // W never holds a pending result, so its tnew is always zero.
    function automatic fwd_sel_t fwd_d(input logic [4:0] x);
        if (src_hit(e_a3, x, e_tnew))      return FWD_E;
        else if (src_hit(m_a3, x, m_tnew)) return FWD_M;
        else if (src_hit(w_a3, x, 2'd0))   return FWD_W;
        else                               return FWD_NONE;
    endfunction

    function automatic fwd_sel_t fwd_e(input logic [4:0] x);
        if (src_hit(m_a3, x, m_tnew))      return FWD_M;
        else if (src_hit(w_a3, x, 2'd0))   return FWD_W;
        else                               return FWD_NONE;
    endfunction

    always_comb begin
        fwd_d_rs = fwd_d(d_rs);
        fwd_d_rt = fwd_d(d_rt);
        fwd_e_rs = fwd_e(e_rs);
        fwd_e_rt = fwd_e(e_rt);
        fwd_m_rt = src_hit(w_a3, m_rt, 2'd0) ? FWD_W : FWD_NONE;
    end

    hazard_stage_rec #(.PW(15), .DEC(1'b0)) u_rec_e (
        .clk       (clk),
        .reset_n   (reset_n),
        .bubble    (stall),
        .d_payload ({d_rs, d_rt, dc.a3}),
        .d_tnew    (dc.tnew),
        .q_payload ({e_rs, e_rt, e_a3}),
        .q_tnew    (e_tnew)
    );

    hazard_stage_rec #(.PW(10), .DEC(1'b1)) u_rec_m (
        .clk       (clk),
        .reset_n   (reset_n),
        .bubble    (1'b0),
        .d_payload ({e_rt, e_a3}),
        .d_tnew    (e_tnew),
        .q_payload ({m_rt, m_a3}),
        .q_tnew    (m_tnew)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_a3 <= '0;
        end else begin
            w_a3 <= m_a3;
        end
    end

endmodule

// File: tb/tb_hazard_tracker.sv
// Randomized and directed check of hazard_tracker against an age-based model
// of in-flight instructions.
module tb_hazard_tracker;

    localparam int NOP = 0, CALC_R = 1, CALC_I = 2, LUI = 3, LOAD = 4,
                   STORE = 5, BRANCH = 6, JR = 7, JL = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       d_calc_r, d_calc_i, d_lui, d_load, d_store, d_branch, d_jr, d_j_l;
    logic [4:0] d_rs, d_rt, d_rd;
    logic       stall;
    logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hazard_tracker dut (
        .clk(clk), .reset_n(reset_n),
        .d_calc_r(d_calc_r), .d_calc_i(d_calc_i), .d_lui(d_lui), .d_load(d_load),
        .d_store(d_store), .d_branch(d_branch), .d_jr(d_jr), .d_j_l(d_j_l),
        .d_rs(d_rs), .d_rt(d_rt), .d_rd(d_rd),
        .stall(stall), .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt),
        .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt), .fwd_m_rt(fwd_m_rt)
    );

    // In-flight instruction; index into pipe[] is its age (0=E, 1=M, 2=W).
    typedef struct {
        int         tnew0;
        logic [4:0] a3, rs, rt;
    } inst_t;

    inst_t pipe[3];
    int    cur_cls;
    logic  m_stall;
    logic  obs_stall;
    logic [1:0] obs_d_rs, obs_d_rt, obs_e_rs, obs_e_rt, obs_m_rt;

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int remaining(input int age);
        int r;
        r = pipe[age].tnew0 - age;
        return (r < 0) ? 0 : r;
    endfunction

    function automatic int tuse_of(input int cls, input bit is_rt);
        case (cls)
            BRANCH: return 0;
            JR:     return is_rt ? -1 : 0;
            CALC_R: return 1;
            CALC_I, LOAD: return is_rt ? -1 : 1;
            STORE:  return is_rt ? 2 : 1;
            default: return -1;
        endcase
    endfunction

    function automatic inst_t decode(input int cls, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [4:0] rd);
        inst_t i;
        i.rs = rs; i.rt = rt; i.a3 = 5'd0; i.tnew0 = 0;
        case (cls)
            CALC_R: begin i.a3 = rd; i.tnew0 = 1; end
            CALC_I, LUI: begin i.a3 = rt; i.tnew0 = 1; end
            LOAD: begin i.a3 = rt; i.tnew0 = 2; end
            JL: begin i.a3 = 5'd31; i.tnew0 = 0; end
            default: ;
        endcase
        return i;
    endfunction

    function automatic bit needs_wait(input logic [4:0] x, input int tuse);
        if (tuse < 0 || x == 5'd0) return 1'b0;
        for (int age = 0; age < 2; age++)
            if (pipe[age].a3 == x && remaining(age) > tuse) return 1'b1;
        return 1'b0;
    endfunction

    // Youngest ready producer among ages [first..2]; result encodes age+1.
    function automatic int source(input logic [4:0] x, input int first);
        if (x == 5'd0) return 0;
        for (int age = first; age < 3; age++)
            if (pipe[age].a3 == x && remaining(age) == 0) return age + 1;
        return 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            pipe[k].tnew0 = 0; pipe[k].a3 = '0; pipe[k].rs = '0; pipe[k].rt = '0;
        end
    endtask

    task automatic drive(input int cls, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd);
        cur_cls = cls;
        d_calc_r = (cls == CALC_R); d_calc_i = (cls == CALC_I); d_lui = (cls == LUI);
        d_load = (cls == LOAD); d_store = (cls == STORE); d_branch = (cls == BRANCH);
        d_jr = (cls == JR); d_j_l = (cls == JL);
        d_rs = rs; d_rt = rt; d_rd = rd;
    endtask

    task automatic compare_all(input string tag);
        m_stall = needs_wait(d_rs, tuse_of(cur_cls, 1'b0)) ||
                  needs_wait(d_rt, tuse_of(cur_cls, 1'b1));
        obs_stall = stall; obs_d_rs = fwd_d_rs; obs_d_rt = fwd_d_rt;
        obs_e_rs = fwd_e_rs; obs_e_rt = fwd_e_rt; obs_m_rt = fwd_m_rt;
        check({tag, ".stall"}, int'(stall), int'(m_stall));
        check({tag, ".fwd_d_rs"}, int'(fwd_d_rs), source(d_rs, 0));
        check({tag, ".fwd_d_rt"}, int'(fwd_d_rt), source(d_rt, 0));
        check({tag, ".fwd_e_rs"}, int'(fwd_e_rs), source(pipe[0].rs, 1));
        check({tag, ".fwd_e_rt"}, int'(fwd_e_rt), source(pipe[0].rt, 1));
        check({tag, ".fwd_m_rt"}, int'(fwd_m_rt),
              (pipe[1].rt != 5'd0 && pipe[2].a3 == pipe[1].rt) ? 3 : 0);
    endtask

    // Drive one D instruction for one cycle, check at negedge, advance model.
    task automatic step(input string tag, input int cls, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd);
        inst_t nxt;
        drive(cls, rs, rt, rd);
        @(negedge clk);
        compare_all(tag);
        nxt = decode(cls, rs, rt, rd);
        if (m_stall) begin
            nxt.tnew0 = 0; nxt.a3 = '0; nxt.rs = '0; nxt.rt = '0;
        end
        @(posedge clk);
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = nxt;
        #1;
    endtask

    function automatic logic [4:0] rnd_reg();
        return ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
    endfunction

    initial begin
        int cls;
        logic [4:0] rs, rt, rd;
        model_reset();
        drive(NOP, 5'd0, 5'd0, 5'd0);
        #2;
        check("reset.stall", int'(stall), 0);
        check("reset.fwd_d_rs", int'(fwd_d_rs), 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // lw $1 ; add $2,$1,$1
        step("lw", LOAD, 5'd0, 5'd1, 5'd0);
        step("add_a", CALC_R, 5'd1, 5'd1, 5'd2);
        check("lw_add.stall1", int'(obs_stall), 1);
        step("add_b", CALC_R, 5'd1, 5'd1, 5'd2);
        check("lw_add.stall_end", int'(obs_stall), 0);
        step("add_e", NOP, 5'd0, 5'd0, 5'd0);
        check("lw_add.fwd_e_rs", int'(obs_e_rs), 3);
        check("lw_add.fwd_e_rt", int'(obs_e_rt), 3);
        repeat (3) step("flush", NOP, 5'd0, 5'd0, 5'd0);

        // lw $1 ; beq $1,$0
        step("lw2", LOAD, 5'd0, 5'd1, 5'd0);
        step("beq_a", BRANCH, 5'd1, 5'd0, 5'd0);
        check("lw_beq.stall1", int'(obs_stall), 1);
        step("beq_b", BRANCH, 5'd1, 5'd0, 5'd0);
        check("lw_beq.stall2", int'(obs_stall), 1);
        step("beq_c", BRANCH, 5'd1, 5'd0, 5'd0);
        check("lw_beq.stall3", int'(obs_stall), 0);
        check("lw_beq.fwd_d_rs", int'(obs_d_rs), 3);
        check("lw_beq.fwd_d_rt", int'(obs_d_rt), 0);

        // jal ; jr $31
        step("jal", JL, 5'd0, 5'd0, 5'd0);
        step("jr", JR, 5'd31, 5'd0, 5'd0);
        check("jal_jr.stall", int'(obs_stall), 0);
        check("jal_jr.fwd_d_rs", int'(obs_d_rs), 1);

        // add $5 ; sw $5,0($6)
        repeat (3) step("flush", NOP, 5'd0, 5'd0, 5'd0);
        step("add5", CALC_R, 5'd1, 5'd2, 5'd5);
        step("sw", STORE, 5'd6, 5'd5, 5'd0);
        check("add_sw.stall", int'(obs_stall), 0);
        step("sw_e", NOP, 5'd0, 5'd0, 5'd0);
        check("add_sw.fwd_e_rt", int'(obs_e_rt), 2);
        step("sw_m", NOP, 5'd0, 5'd0, 5'd0);
        check("add_sw.fwd_m_rt", int'(obs_m_rt), 3);

        // reset during a load-use stall
        step("lw3", LOAD, 5'd0, 5'd1, 5'd0);
        drive(CALC_R, 5'd1, 5'd1, 5'd2);
        @(negedge clk);
        check("rst_mid.stall_before", int'(stall), 1);
        reset_n = 1'b0;
        #1;
        check("rst_mid.stall_low", int'(stall), 0);
        model_reset();
        @(posedge clk);
        #1 reset_n = 1'b1;
        step("rst_mid.after", CALC_R, 5'd1, 5'd1, 5'd2);
        check("rst_mid.no_stall", int'(obs_stall), 0);
        check("rst_mid.no_fwd", int'(obs_d_rs), 0);

        // randomized traffic; a stalled D instruction is held
        cls = NOP; rs = '0; rt = '0; rd = '0;
        for (int n = 0; n < 600; n++) begin
            if (!(n > 0 && m_stall)) begin
                cls = $urandom_range(0, 8);
                rs = rnd_reg(); rt = rnd_reg(); rd = rnd_reg();
            end
            step("rnd", cls, rs, rt, rd);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
